// File: rtl/spectro_pkg.sv
// Shared constants, reader state type and helpers for the spectrogram RAM reader.
// Build option: SPECTRO_RD_OUT_REG_EN selects the RAM's registered output (read latency 2).
package spectro_pkg;

   localparam int unsigned SPEC_ADDR_WIDTH = 9;
   localparam int unsigned SPEC_DATA_WIDTH = 10;
`ifdef SPECTRO_RD_OUT_REG_EN
   localparam int unsigned SPEC_RD_LATENCY = 2;
`else
   localparam int unsigned SPEC_RD_LATENCY = 1;
`endif
   localparam int unsigned SPEC_FIFO_DEPTH = SPEC_RD_LATENCY + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} reader_state_e;

   function automatic int unsigned count_ones(input logic [SPEC_RD_LATENCY-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < int'(SPEC_RD_LATENCY); i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/spectro_skid_fifo.sv
// Small synchronous FIFO that absorbs RAM read data while the stream is stalled.
// Entries carry {last, data}; pushes are never refused, the reader guarantees space.
module spectro_skid_fifo #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [IW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;
   logic             do_pop;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
      return (idx == IW'(DEPTH - 1)) ? '0 : idx + IW'(1);
   endfunction

   assign do_pop = pop && (cnt_q != '0);
   assign head   = mem_q[rd_q];
   assign count  = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= next_idx(wr_q);
         end
         if (do_pop) begin
            rd_q <= next_idx(rd_q);
         end
         case ({push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !do_pop && (cnt_q == CW'(DEPTH))));

endmodule

// File: rtl/spectro_ram_reader.sv
// Port-B read engine: scans one frame of spectrogram bins and streams them out.
// Build option: SPECTRO_RD_OUT_REG_EN (via spectro_pkg) raises the read latency to 2.
module spectro_ram_reader
   import spectro_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SPEC_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = SPEC_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH = SPEC_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_rd_data,
   output logic                  b_wr_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);

   localparam int unsigned LAT = SPEC_RD_LATENCY;
   localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_WIDTH:0] FRAME_LAST = (ADDR_WIDTH + 1)'((1 << ADDR_WIDTH) - 1);

   reader_state_e         state_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, beat_cnt_q;
   logic [ADDR_WIDTH:0]   issue_cnt_q;
   logic [LAT-1:0]        infl_q, infl_d, infl_last_q, infl_last_d;
   logic                  busy_q, done_q;
   logic [FCW-1:0]        fifo_count;
   logic [DATA_WIDTH:0]   fifo_head;
   logic                  issue, pop, push;

   assign pop     = m_valid && m_ready;
   assign push    = infl_q[LAT-1];
   assign m_valid = (fifo_count != '0);
   assign m_data  = fifo_head[DATA_WIDTH-1:0];
   assign m_last  = fifo_head[DATA_WIDTH];
   assign b_addr  = rd_ptr_q;
   assign b_wr_en = 1'b0;
   assign busy    = busy_q;
   assign done    = done_q;

   // A same-cycle pop frees a slot, which keeps one beat per cycle with the minimum depth.
   always_comb begin
      issue = (state_q == READ) && (issue_cnt_q <= FRAME_LAST) &&
              (int'(fifo_count) + int'(count_ones(infl_q)) - int'(pop) < int'(FIFO_DEPTH));
      infl_d[0]      = issue;
      infl_last_d[0] = issue && (issue_cnt_q == FRAME_LAST);
      for (int i = 1; i < int'(LAT); i++) begin
         infl_d[i]      = infl_q[i-1];
         infl_last_d[i] = infl_last_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         issue_cnt_q <= '0;
         beat_cnt_q  <= '0;
         infl_q      <= '0;
         infl_last_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  rd_ptr_q    <= start_addr;
                  issue_cnt_q <= '0;
                  beat_cnt_q  <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= READ;
               end
            end
            READ: begin
               if (issue) begin
                  rd_ptr_q    <= rd_ptr_q + ADDR_WIDTH'(1);
                  issue_cnt_q <= issue_cnt_q + (ADDR_WIDTH + 1)'(1);
                  if (issue_cnt_q == FRAME_LAST) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: state_q <= DRAIN;
            default: state_q <= IDLE;
         endcase
         if (pop) begin
            beat_cnt_q <= beat_cnt_q + ADDR_WIDTH'(1);
         end
         if ((state_q == DRAIN) && pop && (beat_cnt_q == '1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
         end
      end
   end

   spectro_skid_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({infl_last_q[LAT-1], b_rd_data}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_spectro_ram_reader.sv
// Scoreboard bench for spectro_ram_reader with a behavioural port-B RAM model.
// Follows SPECTRO_RD_OUT_REG_EN for the RAM latency and expected frame timing.
module tb_spectro_ram_reader;

   localparam int AW = 9;
   localparam int DW = 10;
   localparam int DEPTH = 512;
`ifdef SPECTRO_RD_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int FRAME_CYCLES = DEPTH + LAT + 1;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk, rst_n, start, busy, done, b_wr_en, m_valid, m_ready, m_last;
   logic [AW-1:0] start_addr, b_addr;
   logic [DW-1:0] b_rd_data, m_data, ram_q;
   logic [DW-1:0] mem [DEPTH];

   beat_t sb[$];
   int    n_checks = 0, n_errors = 0;
   int    cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, beats = 0, d0 = 0;
   logic  bp_mode = 1'b0;

   spectro_ram_reader u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .busy       (busy),
      .done       (done),
      .b_addr     (b_addr),
      .b_rd_data  (b_rd_data),
      .b_wr_en    (b_wr_en),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(1023 - i);
   end

`ifdef SPECTRO_RD_OUT_REG_EN
   always @(posedge clk) begin
      ram_q     <= mem[b_addr];
      b_rd_data <= ram_q;
   end
`else
   always @(posedge clk) b_rd_data <= mem[b_addr];
   assign ram_q = '0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push_frame(input int sa);
      beat_t b;
      for (int j = 0; j < DEPTH; j++) begin
         b.last = (j == DEPTH - 1);
         b.data = DW'(1023 - ((sa + j) % DEPTH));
         sb.push_back(b);
      end
   endtask

   task automatic start_frame(input int sa);
      @(negedge clk); #1;
      start      = 1'b1;
      start_addr = AW'(sa);
      push_frame(sa);
      @(negedge clk); #1;
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n, base;
      n    = 0;
      base = done_cnt;
      while (done_cnt == base && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt != base), 1);
   endtask

   task automatic run_frame(input int sa, input string tag, input bit chk_lat);
      beats = 0;
      start_frame(sa);
      wait_done(tag, 6000);
      if (chk_lat) check({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'(FRAME_CYCLES));
      check({tag, "_beats"}, 32'(beats), 32'(DEPTH));
      check({tag, "_sb_empty"}, 32'(sb.size()), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_b_addr"}, 32'(b_addr), 0);
      check({tag, "_b_wr_en"}, 32'(b_wr_en), 0);
      check({tag, "_m_valid"}, 32'(m_valid), 0);
      check({tag, "_m_data"}, 32'(m_data), 0);
      check({tag, "_m_last"}, 32'(m_last), 0);
   endtask

   // Ready changes just after the rising edge so the monitor sees a settled value.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m_ready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
      end
   end

   initial begin
      logic          prev_stall;
      logic [DW:0]   prev_beat;
      beat_t         e;
      prev_stall = 1'b0;
      prev_beat  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) check("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_beat}));
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (m_valid && m_ready) begin
               beats++;
               if (sb.size() == 0) begin
                  check("extra_beat", 32'({m_last, m_data}), 32'h7fff_ffff);
               end else begin
                  e = sb.pop_front();
                  check("beat", 32'({m_last, m_data}), 32'(e));
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n      = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      run_frame(0, "full", 1'b1);
      run_frame(500, "wrap", 1'b1);

      bp_mode = 1'b1;
      run_frame(0, "bp", 1'b0);
      bp_mode = 1'b0;
      repeat (3) @(negedge clk);

      // Second start mid-frame must be ignored.
      d0    = done_cnt;
      beats = 0;
      start_frame(0);
      repeat (50) @(negedge clk);
      #1;
      start      = 1'b1;
      start_addr = AW'(100);
      @(negedge clk); #1;
      start = 1'b0;
      wait_done("busy_start", 3000);
      check("busy_start_latency", 32'(done_cyc - start_cyc), 32'(FRAME_CYCLES));
      repeat (20) @(negedge clk);
      #1;
      check("busy_start_one_done", 32'(done_cnt - d0), 1);
      check("busy_start_beats", 32'(beats), 32'(DEPTH));
      check("busy_start_idle", 32'(busy), 0);

      // Restart inside the done cycle.
      beats = 0;
      start_frame(0);
      wait_done("b2b_first", 3000);
      check("b2b_done_level", 32'(done), 1);
      start      = 1'b1;
      start_addr = '0;
      push_frame(0);
      @(negedge clk); #1;
      start     = 1'b0;
      start_cyc = cyc;
      wait_done("b2b_second", 3000);
      check("b2b_latency", 32'(done_cyc - start_cyc), 32'(FRAME_CYCLES));
      check("b2b_beats", 32'(beats), 32'(2 * DEPTH));
      check("b2b_sb_empty", 32'(sb.size()), 0);

      // Reset in the middle of a frame.
      beats = 0;
      start_frame(0);
      n = 0;
      while (beats < 200 && n < 2000) begin
         @(negedge clk); #1;
         n++;
      end
      check("mid_reached", 32'(beats >= 200), 1);
      d0    = done_cnt;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      sb.delete();
      repeat (5) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("mid_no_done", 32'(done_cnt - d0), 0);
      check("mid_idle", 32'(busy), 0);
      run_frame(0, "after_reset", 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spectro_ram_reader.md
Name: spectro_ram_reader

Overview:
- Read-side engine for the spectrogram dual-port RAM (512 x 10 bit).
- The FFT writer fills the RAM on port A. This block owns port B: it scans one full frame of bins, starting at a programmable address and wrapping modulo depth.
- It streams the bins to the display/colour-map stage over a valid/ready interface.
- RAM read latency is fixed at 1 cycle (no RAM output register), so a small skid FIFO is needed to absorb backpressure.

Parameters:
- ADDR_WIDTH, 9, RAM port-B address width; frame depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 10, RAM word width and output data width.
- FIFO_DEPTH, 2, skid FIFO entries. Must be >= read latency + 1.

Ports:
- clk, input, 1, single clock for the RAM port B and the stream.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a frame scan. Ignored while busy=1.
- start_addr, input, ADDR_WIDTH, first address of the scan. Sampled when start is accepted.
- busy, output, 1, high from the cycle after start is accepted until the last beat is accepted.
- done, output, 1, one-cycle pulse in the cycle after the last beat handshake.
- b_addr, output, ADDR_WIDTH, RAM port-B address.
- b_rd_data, input, DATA_WIDTH, RAM port-B read data, valid 1 cycle after b_addr is issued.
- b_wr_en, output, 1, tied 0 (port B is read-only here).
- m_data, output, DATA_WIDTH, streamed bin value.
- m_valid, output, 1, stream valid.
- m_ready, input, 1, stream ready.
- m_last, output, 1, high with the final (2**ADDR_WIDTH-th) beat of the frame.

Behaviour:
- Reset values: busy=0, done=0, b_addr=0, b_wr_en=0, m_valid=0, m_data=0, m_last=0, FIFO empty, all counters 0, state IDLE.
- State machine:
  - IDLE: on start, latch start_addr into rd_ptr, clear issue_cnt and beat_cnt, go to READ.
  - READ: issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH and issue_cnt < depth. When issue_cnt reaches depth, go to DRAIN.
  - DRAIN: wait for the FIFO to empty and the last beat to be accepted, then pulse done and return to IDLE.
- Read issue:
  - b_addr = rd_ptr.
  - A read is "issued" in a cycle where the issue condition holds. That cycle sets inflight, and rd_ptr increments modulo 2**ADDR_WIDTH. Wrap from 511 to 0 is natural: no special case.
  - The issue_cnt counter is ADDR_WIDTH+1 bits wide.
  - Next cycle, b_rd_data is pushed into the FIFO, tagged last when it is the depth-th read.
- Stream:
  - m_valid = FIFO non-empty; m_data and m_last come from the FIFO head.
  - A beat transfers when m_valid && m_ready. m_data and m_last must hold stable while m_valid=1 && m_ready=0.
  - Simultaneous push and pop in the same cycle is allowed; fifo_count is unchanged.
- Throughput: with m_ready held at 1, the first beat appears 2 cycles after start is accepted and one beat follows every cycle after that. A frame takes 2**ADDR_WIDTH + 2 cycles from start to done.
- Boundaries:
  - start during busy: ignored, no state change.
  - start in the same cycle as done: accepted (the new frame begins).
  - m_ready low for any length: no data loss, no duplicate beats, reads throttle.
  - FIFO can never overflow because inflight is counted in the issue condition.
  - Reset mid-frame: every register returns to its reset value immediately. The partial frame is discarded and no done pulse is produced.

Optional Feature:
- SPECTRO_RD_OUT_REG_EN defined:
  - The RAM is instantiated with its output register enabled, so read latency is 2.
  - The block tracks two in-flight slots (a 2-bit shift of issue flags).
  - FIFO_DEPTH minimum becomes 3 (the default changes to 3).
  - First beat arrives 3 cycles after start; start to done becomes 2**ADDR_WIDTH + 3 cycles.
- Undefined: latency 1 as described above.

Decomposition:
- Package spectro_pkg:
  - SPEC_ADDR_WIDTH=9, SPEC_DATA_WIDTH=10.
  - SPEC_RD_LATENCY (1, or 2 under the macro).
  - Reader state enum {IDLE, READ, DRAIN}.
- One sub-module, spectro_skid_fifo: synchronous FIFO, width DATA_WIDTH+1 (data+last), depth FIFO_DEPTH. It takes the same clk/rst_n and provides count, push and pop.

Test Plan:
- Full frame, no backpressure: preload RAM[i] = 1023 - i; start_addr = 0; m_ready = 1.
  -> 512 beats of 1023, 1022, ... 512; m_last only on beat 512 (value 512); done exactly 514 cycles after start.
- Wrap: same RAM contents, start_addr = 500.
  -> beats carry values for addresses 500..511 then 0..499; m_last on the beat from address 499 (value 524).
- Backpressure: m_ready driven by a random pattern at 30% high.
  -> the beat sequence is identical to the first scenario, m_data is stable while stalled, and no FIFO overflow assertion fires.
- Start while busy: pulse start again mid-frame with start_addr = 100.
  -> ignored; the frame completes from the original start address; exactly one done pulse.
- Back-to-back frames: pulse start in the done cycle.
  -> the second frame begins immediately and 1024 beats total are received.
- Reset mid-frame: assert rst_n = 0 at beat 200.
  -> all outputs are 0 in the same cycle, no done pulse; a new start after release behaves as the first scenario.
